// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop line sync, centre-sampled bits, LSB first.
// Emits rx_dv on a good stop bit, rx_frame_err on a low stop bit.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 87,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic       rx_dv,
  output logic [7:0] rx_byte,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  // START counts from the cycle after detection, so the centre is one earlier
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_d;
  logic             dv_d, ferr_d;
  logic             rx_m, rx_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = rx_byte;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end
      end
      BRK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m         <= 1'b1;
      rx_s         <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      rx_byte      <= '0;
      rx_dv        <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_m         <= rx_serial;
      rx_s         <= rx_m;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      rx_byte      <= byte_d;
      rx_dv        <= dv_d;
      rx_frame_err <= ferr_d;
      rx_busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: directed frames plus random traffic,
// scored against a frame-level decoder of the recorded line.
module tb_uart_rx_byte;

  localparam int NC = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx8 = 1'b1;
  logic       rx87 = 1'b1;
  logic       dv8, ferr8, busy8;
  logic [7:0] byte8;
  logic       dv87, ferr87, busy87;
  logic [7:0] byte87;

  uart_rx_byte #(.CLKS_PER_BIT(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .rx_serial(rx8),
    .rx_dv(dv8), .rx_byte(byte8),
    .rx_frame_err(ferr8), .rx_busy(busy8)
  );

  uart_rx_byte #(.CLKS_PER_BIT(87), .CNT_W(16)) dut87 (
    .clk(clk), .rst(rst), .rx_serial(rx87),
    .rx_dv(dv87), .rx_byte(byte87),
    .rx_frame_err(ferr87), .rx_busy(busy87)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         e;
    bit         dv;
    bit         er;
    logic [7:0] b;
  } ev_t;

  bit  line8 [NC];
  bit  line87[NC];
  bit  rstv  [NC];
  int  cyc = 0;
  int  bcnt8 = 0;
  ev_t obs8[$];
  ev_t obs87[$];
  ev_t exq[$];
  int  checks = 0;
  int  errors = 0;

  // edge k records the line as sampled at that edge
  always @(posedge clk) begin
    if (cyc < NC) begin
      line8[cyc]  <= rx8;
      line87[cyc] <= rx87;
      rstv[cyc]   <= rst;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (dv8 === 1'b1 || ferr8 === 1'b1)
      obs8.push_back(ev_t'{cyc - 1, dv8 === 1'b1, ferr8 === 1'b1, byte8});
    if (dv87 === 1'b1 || ferr87 === 1'b1)
      obs87.push_back(ev_t'{cyc - 1, dv87 === 1'b1, ferr87 === 1'b1, byte87});
    if (busy8 === 1'b1) bcnt8 <= bcnt8 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask

  // line value the receiver acts on at edge k (two-flop delay, reset to 1)
  function automatic bit sv(input bit sel, input int k);
    if (k < 2) return 1'b1;
    if (rstv[k-1] || rstv[k-2]) return 1'b1;
    return sel ? line87[k-2] : line8[k-2];
  endfunction

  function automatic int nxt_rst(input int from, input int last);
    for (int k = from + 1; k < last; k++)
      if (rstv[k]) return k;
    return last;
  endfunction

  task automatic model(input bit sel, input int cpb, input int last);
    int         half;
    int         k, e0, r, t, j;
    logic [7:0] lb, d;
    half = (cpb - 1) / 2;
    k = 0;
    lb = 8'h00;
    d = 8'h00;
    exq.delete();
    while (k < last) begin
      if (rstv[k]) begin
        lb = 8'h00;
        k++;
      end else if (sv(sel, k)) begin
        k++;
      end else begin
        e0 = k;
        r = nxt_rst(e0, last);
        t = e0 + half + 9 * cpb;
        if (e0 + half >= r) k = r;
        else if (sv(sel, e0 + half)) k = e0 + half + 1;
        else if (t >= r) k = r;
        else begin
          for (int i = 0; i < 8; i++)
            d[i] = sv(sel, e0 + half + (i + 1) * cpb);
          if (sv(sel, t)) begin
            lb = d;
            exq.push_back(ev_t'{t, 1'b1, 1'b0, lb});
            k = t + 1;
          end else begin
            exq.push_back(ev_t'{t, 1'b0, 1'b1, lb});
            j = t + 1;
            while (j < r && !sv(sel, j)) j++;
            k = (j >= r) ? r : j + 1;
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    rx8 = 1'b1;
    rx87 = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // rst_bit >= 0 pulses rst mid frame bit rst_bit and abandons the frame
  task automatic send(input bit sel, input logic [7:0] b, input int per,
                      input bit stopv, input int rst_bit, output int l);
    logic [9:0] f;
    f = {stopv, b, 1'b0};
    l = cyc;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < per; c++) begin
        if (sel) rx87 = f[i];
        else rx8 = f[i];
        rst = (i == rst_bit && c == per / 2);
        @(negedge clk);
        if (rst) begin
          rst = 1'b0;
          rx8 = 1'b1;
          chk("rst_dv", dv8, 1'b0);
          chk("rst_ferr", ferr8, 1'b0);
          chk("rst_busy", busy8, 1'b0);
          chk("rst_byte", byte8, 8'h00);
          return;
        end
      end
    end
  endtask

  task automatic score(input string tag, input bit sel, input int cpb);
    int n;
    model(sel, cpb, cyc - 2);
    n = sel ? obs87.size() : obs8.size();
    chk({tag, "_count"}, n, exq.size());
    for (int i = 0; i < exq.size() && i < n; i++) begin
      ev_t o;
      o = sel ? obs87[i] : obs8[i];
      chk({tag, "_edge"}, o.e, exq[i].e);
      chk({tag, "_dv"}, o.dv, exq[i].dv);
      chk({tag, "_err"}, o.er, exq[i].er);
      chk({tag, "_byte"}, o.b, exq[i].b);
    end
  endtask

  initial begin
    int         l, n0, b0, conv, gap;
    logic [7:0] rb;
    bit         st;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    chk("reset_dv", dv8, 1'b0);
    chk("reset_ferr", ferr8, 1'b0);
    chk("reset_busy", busy8, 1'b0);
    chk("reset_byte", byte8, 8'h00);
    chk("reset_byte87", byte87, 8'h00);
    chk("reset_busy87", busy87, 1'b0);
    idle(10);

    n0 = obs8.size();
    send(1'b0, 8'h35, 8, 1'b1, -1, l);
    idle(20);
    chk("t1_count", obs8.size() - n0, 1);
    chk("t1_edge", obs8[n0].e, l + 2 + 3 + 72);
    chk("t1_dv", obs8[n0].dv, 1'b1);
    chk("t1_byte", byte8, 8'h35);

    n0 = obs8.size();
    send(1'b0, 8'h31, 8, 1'b1, -1, l);
    send(1'b0, 8'h32, 8, 1'b1, -1, l);
    send(1'b0, 8'h33, 8, 1'b1, -1, l);
    idle(20);
    conv = 0;
    for (int i = n0; i < obs8.size(); i++)
      if (obs8[i].dv) conv = conv * 10 + int'(obs8[i].b - 8'h30);
    chk("t2_count", obs8.size() - n0, 3);
    chk("t2_conv", conv, 123);
    chk("t2_gap1", obs8[n0+1].e - obs8[n0].e, 80);
    chk("t2_gap2", obs8[n0+2].e - obs8[n0+1].e, 80);

    n0 = obs8.size();
    b0 = bcnt8;
    rx8 = 1'b0;
    repeat (2) @(negedge clk);
    idle(20);
    chk("t3_busy_max", (bcnt8 - b0) <= 5, 1'b1);
    chk("t3_busy_seen", (bcnt8 - b0) >= 1, 1'b1);
    chk("t3_no_strobe", obs8.size() - n0, 0);

    send(1'b0, 8'h41, 8, 1'b1, -1, l);
    idle(16);
    chk("t4_first", byte8, 8'h41);
    n0 = obs8.size();
    send(1'b0, 8'h42, 8, 1'b0, -1, l);
    rx8 = 1'b0;
    repeat (24) @(negedge clk);
    chk("t4_brk_busy", busy8, 1'b1);
    chk("t4_one_err", obs8.size() - n0, 1);
    chk("t4_err_flag", obs8[n0].er, 1'b1);
    idle(16);
    chk("t4_hold", byte8, 8'h41);
    send(1'b0, 8'h43, 8, 1'b1, -1, l);
    idle(20);
    chk("t4_count", obs8.size() - n0, 2);
    chk("t4_last", byte8, 8'h43);

    n0 = obs8.size();
    send(1'b0, 8'h7E, 8, 1'b1, 5, l);
    idle(30);
    send(1'b0, 8'h39, 8, 1'b1, -1, l);
    idle(20);
    chk("t5_count", obs8.size() - n0, 1);
    chk("t5_byte", obs8[n0].b, 8'h39);

    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 12);
      send(1'b0, rb, 8, st, -1, l);
      if (!st) begin
        rx8 = 1'b0;
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      idle(gap);
    end
    idle(40);

    n0 = obs87.size();
    send(1'b1, 8'h55, 84, 1'b1, -1, l);
    idle(100);
    chk("t6_edge", obs87[n0].e, l + 2 + 43 + 9 * 87);
    send(1'b1, 8'hAA, 90, 1'b1, -1, l);
    idle(200);
    chk("t6_count", obs87.size() - n0, 2);
    chk("t6_b0", obs87[n0].b, 8'h55);
    chk("t6_b1", obs87[n0+1].b, 8'hAA);
    chk("t6_dv", obs87[n0].dv & obs87[n0+1].dv, 1'b1);
    chk("t6_noerr", obs87[n0].er | obs87[n0+1].er, 1'b0);

    score("m8", 1'b0, 8);
    score("m87", 1'b1, 87);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
